// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl
//   Turns the byte stream from a PS/2 byte receiver into keyboard events.
//   A parser FSM recognises the E0 (extended), F0 (break) and E1 (pause)
//   prefixes and throws away device status bytes. Each complete key event
//   {ext, brk, code} goes into a small FIFO that the keyboard-matrix logic
//   drains with a valid/ready handshake.
//
// Handshake: a head entry is presented while ev_valid=1 and is consumed on
//   any clock edge where ev_valid & ev_ready are both high. ev_* stay stable
//   while ev_valid=1 and ev_ready=0.
//
// Optional feature (macro PS2_KBD_TIMEOUT_EN): an inter-byte timeout. It
//   drops a partial multi-byte sequence when the next byte does not arrive
//   within TIMEOUT_CYCLES clocks. Without the macro the parser waits forever.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   rx_done_tick   one-cycle strobe, rx_data valid
//   rx_data[7:0]   received byte
//   rx_en          receive enable back to the byte receiver (low when full)
//   ev_valid/ev_ready, ev_code[7:0], ev_ext, ev_break   event output
//   overflow       sticky "event dropped", cleared by clr_overflow
//   busy           parser is mid-sequence
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_kbd_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

  state_t          state_q, state_d, eff_state;
  logic [2:0]      skip_cnt_q, skip_cnt_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            push, do_push, pop, full, empty;
  logic [9:0]      push_ev;
  logic            tmo_hit;

  function automatic logic is_status(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q != S_IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (rx_done_tick || tmo_hit || state_q == S_IDLE) tmo_cnt_d = '0;
    else                                              tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A byte arriving on the timeout cycle is parsed as if the parser were idle.
  assign eff_state = tmo_hit ? S_IDLE : state_q;

  always_comb begin
    state_d    = eff_state;
    skip_cnt_d = skip_cnt_q;
    push       = 1'b0;
    push_ev    = {2'b00, rx_data};
    if (rx_done_tick) begin
      case (eff_state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      state_d = S_EXT;
          else if (rx_data == 8'hF0) state_d = S_BRK;
          else if (rx_data == 8'hE1) begin
            state_d    = S_SKIP;
            skip_cnt_d = 3'd7;
          end else if (!is_status(rx_data)) push = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0) state_d = S_EXTBRK;
          else begin
            state_d = S_IDLE;
            if (!is_status(rx_data) && !is_prefix(rx_data)) begin
              push    = 1'b1;
              push_ev = {2'b10, rx_data};
            end
          end
        end
        S_BRK, S_EXTBRK: begin
          state_d = S_IDLE;
          if (!is_status(rx_data) && !is_prefix(rx_data)) begin
            push    = 1'b1;
            push_ev = {(eff_state == S_EXTBRK), 1'b1, rx_data};
          end
        end
        S_SKIP: begin
          // Remaining 7 bytes of the fixed 8-byte Pause sequence.
          skip_cnt_d = skip_cnt_q - 1'b1;
          if (skip_cnt_q == 3'd1) begin
            state_d = S_IDLE;
            push    = 1'b1;
            push_ev = {2'b00, 8'hE1};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = !empty && ev_ready;
  // A pop frees the slot in the same cycle, so a push into a full FIFO succeeds.
  assign do_push = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    if (clr_overflow)         overflow_d = 1'b0;
    if (push && !do_push)     overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (do_push) mem_q[wr_ptr_q] <= push_ev;
    end
  end

  assign ev_valid = !empty;
  assign ev_ext   = mem_q[rd_ptr_q][9];
  assign ev_break = mem_q[rd_ptr_q][8];
  assign ev_code  = mem_q[rd_ptr_q][7:0];
  assign overflow = overflow_q;
  assign rx_en    = !full;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
module tb_ps2_kbd_ctrl;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  ps2_kbd_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_en(rx_en), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .overflow(overflow),
    .clr_overflow(clr_overflow), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: compare every consumed event against the expected queue
  always @(negedge clk) begin
    if (reset_n && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got %h (ext,brk,code), required none", {ev_ext, ev_break, ev_code});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({ev_ext, ev_break, ev_code} !== e) begin
          errors++;
          $display("FAIL event: got %h (ext,brk,code), required %h", {ev_ext, ev_break, ev_code}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #2;
    rx_done_tick = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk(name, exp_q.size(), 0);
  endtask

  typedef struct {
    int         n;
    logic [23:0] bytes;
    logic       has_ev;
    logic [9:0] ev;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 24'h1C0000, 1'b1, 10'h01C};
    vecs[1] = '{2, 24'hF01C00, 1'b1, 10'h11C};
    vecs[2] = '{3, 24'hE0F075, 1'b1, 10'h375};
    vecs[3] = '{1, 24'hFA0000, 1'b0, 10'h000};
    vecs[4] = '{2, 24'hE07400, 1'b1, 10'h274};
    vecs[5] = '{2, 24'hE0AA00, 1'b0, 10'h000};
    vecs[6] = '{2, 24'hF0FE00, 1'b0, 10'h000};
    vecs[7] = '{3, 24'hE0F0E0, 1'b0, 10'h000};
    vecs[8] = '{1, 24'h000000, 1'b0, 10'h000};
    vecs[9] = '{2, 24'hE01200, 1'b1, 10'h212};

    // reset
    cycles(3);
    chk("reset_ev_valid", ev_valid, 0);
    chk("reset_ev_code", ev_code, 0);
    chk("reset_ev_flags", {ev_ext, ev_break}, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rx_en", rx_en, 1);
    reset_n = 1'b1;
    cycles(2);

    // single byte latency and pop
    send(8'h1C);
    exp_q.push_back(10'h01C);
    chk("latency_ev_valid", ev_valid, 1);
    chk("latency_ev_code", ev_code, 8'h1C);
    ev_ready = 1'b1;
    cycles(2);
    chk("after_pop_ev_valid", ev_valid, 0);

    // table of sequences
    for (int v = 0; v < 10; v++) begin
      logic [23:0] t;
      t = vecs[v].bytes;
      for (int k = 0; k < vecs[v].n; k++) send(t[23 - 8*k -: 8]);
      if (vecs[v].has_ev) exp_q.push_back(vecs[v].ev);
      cycles(3);
      chk($sformatf("vec%0d_busy", v), busy, 0);
      chk($sformatf("vec%0d_drained", v), exp_q.size(), 0);
    end

    // random plain make codes
    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      b = 8'($urandom_range(8'h01, 8'hA9));
      send(b);
      exp_q.push_back({2'b00, b});
    end
    wait_drain("random_drain");

    // pause sequence
    begin
      logic [63:0] p;
      p = 64'hE1_14_77_E1_F0_14_F0_77;
      exp_q.push_back(10'h0E1);
      for (int k = 0; k < 8; k++) begin
        send(p[63 - 8*k -: 8]);
        chk($sformatf("pause_busy_%0d", k + 1), busy, (k < 7) ? 1 : 0);
      end
      wait_drain("pause_drain");
    end

    // overflow and full handling
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i));
      exp_q.push_back(10'h010 + 10'(i));
    end
    chk("full_rx_en", rx_en, 0);
    send(8'h55);
    chk("overflow_set", overflow, 1);
    chk("full_head_code", ev_code, 8'h10);
    @(posedge clk); #2;
    rx_data = 8'h56; rx_done_tick = 1'b1; clr_overflow = 1'b1;
    @(posedge clk); #2;
    rx_done_tick = 1'b0; clr_overflow = 1'b0;
    chk("overflow_set_wins", overflow, 1);
    ev_ready = 1'b1;
    @(posedge clk); #2;
    ev_ready = 1'b0;
    chk("pop_rx_en", rx_en, 1);
    @(posedge clk); #2;
    clr_overflow = 1'b1;
    @(posedge clk); #2;
    clr_overflow = 1'b0;
    chk("overflow_clr", overflow, 0);
    send(8'h60);
    exp_q.push_back(10'h060);
    chk("refill_rx_en", rx_en, 0);
    @(posedge clk); #2;
    ev_ready = 1'b1; rx_data = 8'h61; rx_done_tick = 1'b1;
    exp_q.push_back(10'h061);
    @(posedge clk); #2;
    rx_done_tick = 1'b0;
    chk("full_push_pop_no_overflow", overflow, 0);
    wait_drain("overflow_drain");

    // inter-byte timeout
    send(8'hE0);
    cycles(TMO);
`ifdef PS2_KBD_TIMEOUT_EN
    chk("timeout_busy", busy, 0);
    exp_q.push_back(10'h01C);
`else
    chk("no_timeout_busy", busy, 1);
    exp_q.push_back(10'h21C);
`endif
    send(8'h1C);
    wait_drain("timeout_drain");

    // reset mid-sequence with queued events
    ev_ready = 1'b0;
    send(8'h21); send(8'h22); send(8'h23);
    send(8'hE0);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_ev_valid", ev_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_rx_en", rx_en, 1);
    @(posedge clk); #2;
    reset_n = 1'b1;
    ev_ready = 1'b1;
    send(8'h1C);
    exp_q.push_back(10'h01C);
    wait_drain("post_reset_drain");

    cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
